uart_tx_buffer: RTL and testbench

Byte FIFO and transmit scheduler placed between the UART receiver and the UART transmitter in the loopback path. It captures every received byte on the receiver's one-cycle data-ready strobe, stores up to 2^DEPTH_LOG2 bytes, and feeds them to the transmitter one at a time with a ready/busy handshake. Back-to-back received bytes are therefore not lost while the transmitter is still shifting out an earlier byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_byte_fifo.sv | 78 +++++++
 rtl/uart_tx_buffer.sv | 101 ++++++++++
 tb/tb_uart_tx_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback path: byte width, default buffer
// depth and the transmit-scheduler state encoding.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t IDLE       = 2'd0;
  localparam drain_state_t WAIT_START = 2'd1;
  localparam drain_state_t WAIT_END   = 2'd2;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte store with registered occupancy and full/empty flags.
// A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [BYTE_W-1:0]     push_data,
  input  logic                  pop,
  output logic [BYTE_W-1:0]     pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  push_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

  logic [BYTE_W-1:0]     mem_r [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  empty_r;
  logic                  full_r;
  logic                  pop_en_s;
  logic                  push_en_s;

  assign pop_en_s  = pop & ~empty_r;
  assign push_en_s = push & (~full_r | pop_en_s);

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_en_s, pop_en_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_en_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_en_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign push_drop = push & ~push_en_s;

endmodule

// File: rtl/uart_tx_buffer.sv
// Receive-to-transmit byte buffer with a one-byte-in-flight drain scheduler.
// Optional sticky drop flag o_OVERFLOW is built when UART_TX_BUFFER_OVERFLOW_EN is defined.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  input  logic                i_rx_DATA_READY,
  input  logic [BYTE_W-1:0]   i_rx_DATA,
  input  logic                i_tx_BUSY,
  output logic                o_tx_DATA_READY,
  output logic [BYTE_W-1:0]   o_tx_DATA,
  output logic [DEPTH_LOG2:0] o_COUNT,
  output logic                o_EMPTY,
  output logic                o_FULL
`ifdef UART_TX_BUFFER_OVERFLOW_EN
  , output logic              o_OVERFLOW
`endif
);

  drain_state_t        state_r;
  drain_state_t        state_nxt_s;
  logic                launch_s;
  logic                tx_rdy_r;
  logic [BYTE_W-1:0]   tx_data_r;
  logic [BYTE_W-1:0]   head_s;
  logic                empty_s;
  logic                drop_s;

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (i_CLK),
    .rst       (i_RESET),
    .push      (i_rx_DATA_READY),
    .push_data (i_rx_DATA),
    .pop       (launch_s),
    .pop_data  (head_s),
    .count     (o_COUNT),
    .empty     (empty_s),
    .full      (o_FULL),
    .push_drop (drop_s)
  );

  assign launch_s = (state_r == IDLE) & ~empty_s & ~i_tx_BUSY;

  // Drain scheduler next state: launch, wait for busy rise, wait for busy fall
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nxt_s = WAIT_START;
        else          state_nxt_s = IDLE;
      end
      WAIT_START: begin
        if (i_tx_BUSY) state_nxt_s = WAIT_END;
        else           state_nxt_s = WAIT_START;
      end
      WAIT_END: begin
        if (!i_tx_BUSY) state_nxt_s = IDLE;
        else            state_nxt_s = WAIT_END;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered transmitter outputs; o_tx_DATA holds between launches
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_r   <= IDLE;
      tx_rdy_r  <= 1'b0;
      tx_data_r <= {BYTE_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      tx_rdy_r <= launch_s;
      if (launch_s) tx_data_r <= head_s;
    end
  end

  assign o_tx_DATA_READY = tx_rdy_r;
  assign o_tx_DATA       = tx_data_r;
  assign o_EMPTY         = empty_s;

`ifdef UART_TX_BUFFER_OVERFLOW_EN
  logic overflow_r;

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge i_CLK) begin
    if (i_RESET)     overflow_r <= 1'b0;
    else if (drop_s) overflow_r <= 1'b1;
  end

  assign o_OVERFLOW = overflow_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed scoreboard bench for uart_tx_buffer with a transmitter busy model.
// Overflow checks are compiled in when UART_TX_BUFFER_OVERFLOW_EN is defined.
module tb_uart_tx_buffer;

  logic       i_CLK = 1'b0;
  logic       i_RESET;
  logic       i_rx_DATA_READY;
  logic [7:0] i_rx_DATA;
  logic       i_tx_BUSY;
  logic       o_tx_DATA_READY;
  logic [7:0] o_tx_DATA;
  logic [4:0] o_COUNT;
  logic       o_EMPTY;
  logic       o_FULL;
`ifdef UART_TX_BUFFER_OVERFLOW_EN
  logic       o_OVERFLOW;
`endif

  logic       model_busy = 1'b0;
  logic       hold_busy  = 1'b0;
  int         tx_len     = 4;
  int         cyc        = 0;
  int         fall_cyc   = 0;
  int         checks     = 0;
  int         errors     = 0;
  logic [7:0] exp_q[$];

  assign i_tx_BUSY = model_busy | hold_busy;

  uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
    .i_CLK           (i_CLK),
    .i_RESET         (i_RESET),
    .i_rx_DATA_READY (i_rx_DATA_READY),
    .i_rx_DATA       (i_rx_DATA),
    .i_tx_BUSY       (i_tx_BUSY),
    .o_tx_DATA_READY (o_tx_DATA_READY),
    .o_tx_DATA       (o_tx_DATA),
    .o_COUNT         (o_COUNT),
    .o_EMPTY         (o_EMPTY),
    .o_FULL          (o_FULL)
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    , .o_OVERFLOW    (o_OVERFLOW)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  always @(posedge i_CLK) cyc = cyc + 1;

  always @(negedge i_tx_BUSY) fall_cyc = cyc;

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    i_rx_DATA_READY = 1'b1;
    i_rx_DATA       = b;
    if (accept) exp_q.push_back(b);
    tick();
    i_rx_DATA_READY = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && o_EMPTY && !i_tx_BUSY) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    repeat (tx_len + 6) tick();
  endtask

  // Transmitter model: busy for tx_len cycles after each launch strobe
  initial begin
    forever begin
      @(posedge i_CLK);
      #1;
      if (o_tx_DATA_READY) begin
        model_busy = 1'b1;
        repeat (tx_len) @(posedge i_CLK);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  // Launch monitor: pops the scoreboard and compares each launched byte
  initial begin
    logic [7:0] expv;
    forever begin
      @(posedge i_CLK);
      #1;
      if (o_tx_DATA_READY) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL launch_unexpected: observed %0h expected none", o_tx_DATA);
        end
        if (exp_q.size() > 0) begin
          expv = exp_q.pop_front();
          checks++;
          assert (o_tx_DATA === expv) else begin
            errors++;
            $error("FAIL launch_data: observed %0h expected %0h", o_tx_DATA, expv);
          end
          checks++;
          assert (cyc - fall_cyc >= 1) else begin
            errors++;
            $error("FAIL launch_gap: observed %0d expected >=1", cyc - fall_cyc);
          end
        end
      end
    end
  end

  initial begin
    i_RESET         = 1'b1;
    i_rx_DATA_READY = 1'b0;
    i_rx_DATA       = 8'h00;
    repeat (3) tick();
    i_RESET = 1'b0;
    chk("rst_count", 32'(o_COUNT), 32'd0);
    chk("rst_empty", 32'(o_EMPTY), 32'd1);
    chk("rst_full", 32'(o_FULL), 32'd0);
    chk("rst_rdy", 32'(o_tx_DATA_READY), 32'd0);
    chk("rst_data", 32'(o_tx_DATA), 32'h00);
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    chk("rst_ovf", 32'(o_OVERFLOW), 32'd0);
`endif

    // Single byte: launch exactly two cycles after the strobe
    tx_len = 4;
    push_byte(8'hA5, 1'b1);
    chk("lat_c1_count", 32'(o_COUNT), 32'd1);
    chk("lat_c1_empty", 32'(o_EMPTY), 32'd0);
    chk("lat_c1_rdy", 32'(o_tx_DATA_READY), 32'd0);
    tick();
    chk("lat_c2_rdy", 32'(o_tx_DATA_READY), 32'd1);
    chk("lat_c2_data", 32'(o_tx_DATA), 32'hA5);
    chk("lat_c2_count", 32'(o_COUNT), 32'd0);
    tick();
    chk("lat_c3_rdy", 32'(o_tx_DATA_READY), 32'd0);
    chk("lat_c3_hold", 32'(o_tx_DATA), 32'hA5);
    wait_drain(200);

    // Back-to-back strobes against a slow transmitter
    tx_len = 100;
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    push_byte(8'h33, 1'b1);
    wait_drain(1000);

    // Fill to full with busy held, then drop one byte
    tx_len    = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    chk("full_count", 32'(o_COUNT), 32'd16);
    chk("full_flag", 32'(o_FULL), 32'd1);
    push_byte(8'h10, 1'b0);
    chk("drop_count", 32'(o_COUNT), 32'd16);
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    chk("drop_ovf", 32'(o_OVERFLOW), 32'd1);
`endif
    hold_busy = 1'b0;
    wait_drain(500);
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    chk("ovf_sticky", 32'(o_OVERFLOW), 32'd1);
`endif

    // Push at full in the same cycle as a launch
    i_RESET = 1'b1;
    tick();
    i_RESET   = 1'b0;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
    chk("full2_flag", 32'(o_FULL), 32'd1);
    i_rx_DATA_READY = 1'b1;
    i_rx_DATA       = 8'hEE;
    exp_q.push_back(8'hEE);
    hold_busy = 1'b0;
    tick();
    i_rx_DATA_READY = 1'b0;
    chk("simul_count", 32'(o_COUNT), 32'd16);
    chk("simul_launch", 32'(o_tx_DATA_READY), 32'd1);
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    chk("simul_ovf", 32'(o_OVERFLOW), 32'd0);
`endif
    wait_drain(500);

    // Twenty bytes in groups so the pointers wrap
    tx_len = 8;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(g * 5 + i), 1'b1);
      repeat (20) tick();
    end
    wait_drain(1000);

    // Reset while the scheduler waits for the end of a frame
    tx_len = 50;
    for (int i = 0; i < 6; i++) push_byte(8'h80 + 8'(i), 1'b1);
    repeat (10) tick();
    chk("pre_rst_busy", 32'(i_tx_BUSY), 32'd1);
    chk("pre_rst_count", 32'(o_COUNT), 32'd5);
    i_RESET = 1'b1;
    exp_q.delete();
    tick();
    i_RESET = 1'b0;
    chk("mid_rst_count", 32'(o_COUNT), 32'd0);
    chk("mid_rst_empty", 32'(o_EMPTY), 32'd1);
    chk("mid_rst_full", 32'(o_FULL), 32'd0);
    chk("mid_rst_rdy", 32'(o_tx_DATA_READY), 32'd0);
    chk("mid_rst_data", 32'(o_tx_DATA), 32'h00);
`ifdef UART_TX_BUFFER_OVERFLOW_EN
    chk("mid_rst_ovf", 32'(o_OVERFLOW), 32'd0);
`endif
    repeat (120) tick();
    chk("post_rst_data", 32'(o_tx_DATA), 32'h00);
    tx_len = 4;
    push_byte(8'h5A, 1'b1);
    wait_drain(200);
    chk("final_data", 32'(o_tx_DATA), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
